// File: rtl/lcd_sequencer.sv
// HD44780 4-bit write-only sequencer: power-on init and display configuration,
// then host bytes sent as high/low nibble strobes with the required delays.
//
// state         | meaning
// S_RESET       | power-on wait before the first nibble
// S_INIT_STROBE | strobing one of the 0x3,0x3,0x3,0x2 init nibbles
// S_INIT_WAIT   | post-nibble wait, length depends on init_idx
// S_HI_STROBE   | strobing the high nibble of byte_q
// S_GAP         | wait between high and low nibble
// S_LO_STROBE   | strobing the low nibble of byte_q
// S_EXEC        | execution wait (clear or short), then next config byte or IDLE
// S_IDLE        | ready for a host byte
module lcd_sequencer #(
   parameter int unsigned T_POWERON = 750000,
   parameter int unsigned T_INIT1   = 205000,
   parameter int unsigned T_INIT2   = 5000,
   parameter int unsigned T_SHORT   = 2000,
   parameter int unsigned T_CLEAR   = 82000,
   parameter int unsigned T_GAP     = 50,
   parameter int unsigned T_SETUP   = 2,
   parameter int unsigned T_PULSE   = 12,
   parameter int unsigned T_HOLD    = 1,
   parameter int unsigned CNT_W     = 20
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iWriteRequest,
   input  logic       iRS,
   input  logic [7:0] iData,
   output logic       oReady,
   output logic       oInitDone,
   output logic       oLCD_E,
   output logic       oLCD_RS,
   output logic       oLCD_RW,
   output logic [3:0] oLCD_Data
);

   typedef enum logic [2:0] {
      S_RESET, S_INIT_STROBE, S_INIT_WAIT, S_HI_STROBE,
      S_GAP, S_LO_STROBE, S_EXEC, S_IDLE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_PON   = CNT_W'(T_POWERON - 1);
   localparam logic [CNT_W-1:0] LAST_INIT1 = CNT_W'(T_INIT1 - 1);
   localparam logic [CNT_W-1:0] LAST_INIT2 = CNT_W'(T_INIT2 - 1);
   localparam logic [CNT_W-1:0] LAST_SHORT = CNT_W'(T_SHORT - 1);
   localparam logic [CNT_W-1:0] LAST_CLEAR = CNT_W'(T_CLEAR - 1);
   localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(T_GAP - 1);
   localparam logic [CNT_W-1:0] LAST_STB   = CNT_W'(T_SETUP + T_PULSE + T_HOLD - 1);
   localparam logic [CNT_W-1:0] E_ON       = CNT_W'(T_SETUP);
   localparam logic [CNT_W-1:0] E_OFF      = CNT_W'(T_SETUP + T_PULSE);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] init_last;
   logic [CNT_W-1:0] exec_last;
   logic             e_next;
   logic [1:0]       init_idx;
   logic [1:0]       cfg_idx;
   logic             cfg_mode;
   logic [7:0]       byte_q;
   logic             rs_q;
   logic [7:0]       cfg_next;

   assign oLCD_RW = 1'b0;

   always_comb begin
      cnt_inc = cnt + 1'b1;
      // E is registered, so it follows the counter value being loaded this edge
      e_next  = (cnt_inc >= E_ON) && (cnt_inc < E_OFF);
      case (init_idx)
         2'd0:    init_last = LAST_INIT1;
         2'd1:    init_last = LAST_INIT2;
         default: init_last = LAST_SHORT;
      endcase
      exec_last = (byte_q == 8'h01 && !rs_q) ? LAST_CLEAR : LAST_SHORT;
      case (cfg_idx)
         2'd0:    cfg_next = 8'h06;
         2'd1:    cfg_next = 8'h0C;
         default: cfg_next = 8'h01;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state     <= S_RESET;
         cnt       <= '0;
         oLCD_E    <= 1'b0;
         oLCD_RS   <= 1'b0;
         oLCD_Data <= 4'h0;
         oReady    <= 1'b0;
         oInitDone <= 1'b0;
         init_idx  <= 2'd0;
         cfg_idx   <= 2'd0;
         cfg_mode  <= 1'b0;
         byte_q    <= 8'h00;
         rs_q      <= 1'b0;
      end else begin
         case (state)
            S_RESET: begin
               if (cnt == LAST_PON) begin
                  cnt       <= '0;
                  init_idx  <= 2'd0;
                  oLCD_RS   <= 1'b0;
                  oLCD_Data <= 4'h3;
                  state     <= S_INIT_STROBE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_INIT_STROBE, S_HI_STROBE, S_LO_STROBE: begin
               if (cnt == LAST_STB) begin
                  cnt    <= '0;
                  oLCD_E <= 1'b0;
                  if (state == S_INIT_STROBE)    state <= S_INIT_WAIT;
                  else if (state == S_HI_STROBE) state <= S_GAP;
                  else                           state <= S_EXEC;
               end else begin
                  cnt    <= cnt_inc;
                  oLCD_E <= e_next;
               end
            end
            S_INIT_WAIT: begin
               if (cnt == init_last) begin
                  cnt <= '0;
                  if (init_idx == 2'd3) begin
                     cfg_mode  <= 1'b1;
                     cfg_idx   <= 2'd0;
                     byte_q    <= 8'h28;
                     rs_q      <= 1'b0;
                     oLCD_RS   <= 1'b0;
                     oLCD_Data <= 4'h2;
                     state     <= S_HI_STROBE;
                  end else begin
                     init_idx  <= init_idx + 2'd1;
                     oLCD_Data <= (init_idx == 2'd2) ? 4'h2 : 4'h3;
                     state     <= S_INIT_STROBE;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_GAP: begin
               if (cnt == LAST_GAP) begin
                  cnt       <= '0;
                  oLCD_Data <= byte_q[3:0];
                  state     <= S_LO_STROBE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_EXEC: begin
               if (cnt == exec_last) begin
                  cnt <= '0;
                  if (cfg_mode && cfg_idx != 2'd3) begin
                     cfg_idx   <= cfg_idx + 2'd1;
                     byte_q    <= cfg_next;
                     oLCD_Data <= cfg_next[7:4];
                     state     <= S_HI_STROBE;
                  end else begin
                     cfg_mode  <= 1'b0;
                     oReady    <= 1'b1;
                     oInitDone <= 1'b1;
                     state     <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_IDLE: begin
               if (iWriteRequest) begin
                  byte_q    <= iData;
                  rs_q      <= iRS;
                  oLCD_RS   <= iRS;
                  oLCD_Data <= iData[7:4];
                  oReady    <= 1'b0;
                  cnt       <= '0;
                  state     <= S_HI_STROBE;
               end
            end
            default: state <= S_RESET;
         endcase
      end
   end

endmodule
